seq_divider_njp: RTL and testbench
==================================

// Module: seq_divider_njp
// PURPOSE
//   Sequential restoring divider: unsigned DW-bit dividend / VW-bit divisor -> DW-bit quotient + VW-bit remainder.
//   Inverse companion to the shift-add micro multiplier; sits beside it in the tt_um top-level.
//   The top level drives operands from ui_in and the multiplier product path, and muxes results onto uo_out.
//   One quotient bit per clock; FSM control and datapath live in one module.
// PARAMETERS
//   DW  8  dividend / quotient width (bits)
//   VW  4  divisor / remainder width (bits); VW <= DW
// PORTS
//   sys_clk      in   1   system clock, rising edge
//   sys_rst      in   1   asynchronous, active-high reset
//   start        in   1   request division; sampled only in IDLE
//   dividend     in   DW  unsigned dividend, sampled with start
//   divisor      in   VW  unsigned divisor, sampled with start
//   busy         out  1   high from the cycle after accepted start until done drops
//   done         out  1   one-cycle pulse: quotient/remainder/div_by_zero valid and updated
//   quotient     out  DW  registered result, held until next done
//   remainder    out  VW  registered result, held until next done
//   div_by_zero  out  1   registered flag, updated with done
// BEHAVIOUR
//   Reset (async, any state): state=IDLE; busy, done, quotient, remainder, div_by_zero, counter all 0.
//   FSM states: IDLE, ITER, FINISH.
//   IDLE:
//     - start=1 at edge, divisor!=0: latch dividend into Q shift reg; R(VW+1 bits)=0; D=divisor; cnt=DW; -> ITER.
//     - start=1 at edge, divisor==0: -> FINISH with dbz pending; no iterations.
//   ITER, per edge:
//     - R'={R[VW-1:0],Q[DW-1]}; Q'={Q[DW-2:0],0}.
//     - If R'>=D: R'=R'-D, Q'[0]=1.
//     - cnt--; cnt reaches 0 -> FINISH.
//   FINISH (one cycle):
//     - done=1; quotient=Q, remainder=R[VW-1:0], div_by_zero=0; at edge -> IDLE.
//     - On dbz pending: quotient={DW{1}}, remainder=0, div_by_zero=1.
//   busy=1 in ITER and FINISH; busy=0 in IDLE.
//   Latency: start sampled at edge 0.
//     - Normal: done high in cycle DW+1 (edges 1..DW iterate); 9 cycles for DW=8.
//     - Divide by zero: done high in cycle 1.
//   start while busy (ITER/FINISH) is ignored, not queued; operand changes while busy have no effect.
//   Back-to-back: start may be accepted in the first IDLE cycle after done (throughput DW+2 cycles).
//   quotient/remainder/div_by_zero change only in the done cycle; intermediate Q/R never visible on outputs.
//   Arithmetic: R is VW+1 bits so the shifted partial remainder never overflows; compare/subtract unsigned.
//   Invariant: dividend == quotient*divisor + remainder, with remainder < divisor (divisor!=0).
//   Reset mid-operation: aborts immediately; outputs return to 0; no done pulse.
// TESTING
//   200/7: start 1 cycle -> busy next cycle; done pulses 9 cycles after start edge; quotient=28, remainder=4, dbz=0.
//   255/1 then 255/15 back-to-back: quotient=255 r=0, then quotient=17 r=0; second start 1 cycle after first done.
//   13/0: done 1 cycle after start; quotient=8'hFF, remainder=0, div_by_zero=1; next 5/9 gives q=0, r=5, dbz=0.
//   start pulsed with 100/3 during ITER of a 50/6 op: ignored; result q=8, r=2; exactly one done pulse.
//   Reset asserted at iteration 4 of 200/7: all outputs 0 asynchronously, busy=0, no done; fresh 0/5 -> q=0, r=0.
//   Random 1000 operand pairs vs reference model: q*d+r==dividend, r<d, done exactly DW+1 cycles after start.

Source files
------------

// File: rtl/seq_divider_njp.sv
// Sequential restoring divider: DW-bit dividend / VW-bit divisor, one quotient bit per clock.
// Results are registered on the edge entering FINISH, so they appear with the done pulse.
module seq_divider_njp #(
  parameter int DW = 8,
  parameter int VW = 4
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_by_zero
);

  localparam int CW = $clog2(DW + 1);

  typedef enum logic [1:0] {IDLE, ITER, FINISH} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] shq_q, shq_d;
  logic [VW:0]   rem_q, rem_d;
  logic [VW-1:0] dvs_q, dvs_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] quo_q, quo_d;
  logic [VW-1:0] remOut_q, remOut_d;
  logic          dbz_q, dbz_d;

  logic [VW:0]   rShift, rSub, rNext;
  logic [DW-1:0] qShift, qNext;
  logic          fits;

  // One restoring step: shift in the next dividend bit, subtract if the divisor fits.
  always_comb begin
    rShift = (rem_q << 1) | (VW+1)'(shq_q[DW-1]);
    qShift = shq_q << 1;
    fits   = (rShift >= {1'b0, dvs_q});
    rSub   = rShift - {1'b0, dvs_q};
    rNext  = fits ? rSub : rShift;
    qNext  = qShift | DW'(fits);
  end

  always_comb begin
    state_d  = state_q;
    shq_d    = shq_q;
    rem_d    = rem_q;
    dvs_d    = dvs_q;
    cnt_d    = cnt_q;
    quo_d    = quo_q;
    remOut_d = remOut_q;
    dbz_d    = dbz_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (divisor == '0) begin
            quo_d    = '1;
            remOut_d = '0;
            dbz_d    = 1'b1;
            state_d  = FINISH;
          end else begin
            shq_d   = dividend;
            rem_d   = '0;
            dvs_d   = divisor;
            cnt_d   = CW'(DW);
            state_d = ITER;
          end
        end
      end
      ITER: begin
        shq_d = qNext;
        rem_d = rNext;
        cnt_d = cnt_q - 1'b1;
        // Final step: publish the result so it is valid during the done cycle.
        if (cnt_q == CW'(1)) begin
          quo_d    = qNext;
          remOut_d = rNext[VW-1:0];
          dbz_d    = 1'b0;
          state_d  = FINISH;
        end
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q  <= IDLE;
      shq_q    <= '0;
      rem_q    <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
      quo_q    <= '0;
      remOut_q <= '0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      shq_q    <= shq_d;
      rem_q    <= rem_d;
      dvs_q    <= dvs_d;
      cnt_q    <= cnt_d;
      quo_q    <= quo_d;
      remOut_q <= remOut_d;
      dbz_q    <= dbz_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = (state_q == FINISH);
  assign quotient    = quo_q;
  assign remainder   = remOut_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider_njp.sv
// Scoreboard bench for seq_divider_njp: expectations queued at start, popped on each done pulse.
module tb_seq_divider_njp;

  localparam int DW = 8;
  localparam int VW = 4;

  logic          sys_clk = 1'b0;
  logic          sys_rst = 1'b1;
  logic          start = 1'b0;
  logic [DW-1:0] dividend = '0;
  logic [VW-1:0] divisor = '0;
  logic          busy, done, div_by_zero;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;

  typedef struct {
    int dd;
    int dv;
    int q;
    int r;
    int z;
  } exp_t;

  exp_t sb[$];
  int   nChecks = 0;
  int   nFails = 0;
  int   doneCount = 0;

  seq_divider_njp #(.DW(DW), .VW(VW)) dut (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .start(start),
    .dividend(dividend),
    .divisor(divisor),
    .busy(busy),
    .done(done),
    .quotient(quotient),
    .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic checkOutput(input string tag, input int obs, input int expv);
    nChecks++;
    if (obs !== expv) begin
      nFails++;
      $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  // Every done pulse must match the oldest outstanding expectation.
  always @(negedge sys_clk) begin
    if (done) begin
      exp_t e;
      doneCount++;
      if (sb.size() == 0) begin
        checkOutput("unexpected_done", 1, 0);
      end else begin
        e = sb.pop_front();
        checkOutput("quotient", int'(quotient), e.q);
        checkOutput("remainder", int'(remainder), e.r);
        checkOutput("div_by_zero", int'(div_by_zero), e.z);
        if (e.dv != 0) begin
          checkOutput("invariant", int'(quotient) * e.dv + int'(remainder), e.dd);
          checkOutput("rem_lt_div", int'(int'(remainder) < e.dv), 1);
        end
      end
    end
  end

  task automatic applyStimulus(input logic [DW-1:0] dd, input logic [VW-1:0] dv, input int injectAt);
    exp_t e;
    int   cyc;
    int   expLat;
    e.dd = int'(dd);
    e.dv = int'(dv);
    if (dv == '0) begin
      e.q = 255; e.r = 0; e.z = 1; expLat = 1;
    end else begin
      e.q = int'(dd) / int'(dv); e.r = int'(dd) % int'(dv); e.z = 0; expLat = DW + 1;
    end
    @(negedge sys_clk);
    start = 1'b1;
    dividend = dd;
    divisor = dv;
    sb.push_back(e);
    @(posedge sys_clk);
    #1;
    start = 1'b0;
    dividend = 8'($urandom_range(0, 255));
    divisor = 4'($urandom_range(0, 15));
    checkOutput("busy_after_start", int'(busy), 1);
    cyc = 1;
    while (!done && cyc < DW + 10) begin
      if (cyc == injectAt) begin
        start = 1'b1; dividend = 8'd100; divisor = 4'd3;
      end else begin
        start = 1'b0;
      end
      @(posedge sys_clk);
      #1;
      cyc++;
    end
    start = 1'b0;
    checkOutput("done_seen", int'(done), 1);
    checkOutput("latency", cyc, expLat);
    @(posedge sys_clk);
    #1;
    checkOutput("busy_idle", int'(busy), 0);
    checkOutput("hold_quotient", int'(quotient), e.q);
  endtask

  initial begin
    int dc0;
    #1;
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_done", int'(done), 0);
    checkOutput("rst_quotient", int'(quotient), 0);
    checkOutput("rst_remainder", int'(remainder), 0);
    checkOutput("rst_dbz", int'(div_by_zero), 0);
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b0;

    applyStimulus(8'd200, 4'd7, 0);
    applyStimulus(8'd255, 4'd1, 0);
    applyStimulus(8'd255, 4'd15, 0);
    applyStimulus(8'd13, 4'd0, 0);
    applyStimulus(8'd5, 4'd9, 0);

    // A start pulse in the middle of an operation must be dropped entirely.
    dc0 = doneCount;
    applyStimulus(8'd50, 4'd6, 3);
    repeat (DW + 4) @(negedge sys_clk);
    checkOutput("single_done", doneCount - dc0, 1);
    checkOutput("sb_empty", sb.size(), 0);

    // Asynchronous reset partway through 200/7.
    @(negedge sys_clk);
    start = 1'b1; dividend = 8'd200; divisor = 4'd7;
    @(posedge sys_clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge sys_clk);
    #2;
    sys_rst = 1'b1;
    #1;
    checkOutput("abort_busy", int'(busy), 0);
    checkOutput("abort_done", int'(done), 0);
    checkOutput("abort_quotient", int'(quotient), 0);
    checkOutput("abort_remainder", int'(remainder), 0);
    checkOutput("abort_dbz", int'(div_by_zero), 0);
    dc0 = doneCount;
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b0;
    repeat (DW + 4) @(negedge sys_clk);
    checkOutput("abort_no_done", doneCount - dc0, 0);
    applyStimulus(8'd0, 4'd5, 0);

    for (int i = 0; i < 1000; i++) begin
      applyStimulus(8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)), 0);
    end

    repeat (4) @(negedge sys_clk);
    checkOutput("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
